viterbi_codec: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder and hard-decision Viterbi decoder in one block. The two paths are independent: the encoder feeds a channel, and the decoder takes the symbols back from that channel. Link testbenches use this block to measure how well the code corrects channel errors. The encoder uses generators g1 = 111 and g0 = 101 (octal 7,5); the decoder is a 4-state add-compare-select (ACS) engine with register-exchange survivor memory.

---
 rtl/viterbi_codec.sv | 136 +++++++++++++
 tb/tb_viterbi_codec.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 (octal 7,5) convolutional encoder and a 4-state hard-decision
// Viterbi decoder with register-exchange survivor memory. The two paths are independent.
module viterbi_codec #(
  parameter int TB_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_encoder_i,
  input  logic       encoder_i,
  output logic       valid_encoder_o,
  output logic [1:0] encoder_o,
  input  logic       enable_decoder_i,
  input  logic [1:0] decoder_i,
  output logic       decoder_o,
  output logic       decoder_valid_o
);

  localparam int D  = TB_DEPTH;
  localparam int CW = $clog2(D + 1);
  // Decoding assumes the encoder starts in state 0, so the other states start penalised.
  localparam logic [3:0][5:0] PM_INIT = {6'd16, 6'd16, 6'd16, 6'd0};

  logic [1:0] enc_state_q, enc_state_d;
  logic [1:0] enc_sym_q, enc_sym_d;
  logic       enc_valid_q, enc_valid_d;

  always_comb begin
    enc_state_d = enc_state_q;
    enc_sym_d   = enc_sym_q;
    enc_valid_d = 1'b0;
    if (enable_encoder_i) begin
      enc_sym_d   = {encoder_i ^ enc_state_q[1] ^ enc_state_q[0], encoder_i ^ enc_state_q[0]};
      enc_state_d = {encoder_i, enc_state_q[1]};
      enc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state_q <= 2'b00;
      enc_sym_q   <= 2'b00;
      enc_valid_q <= 1'b0;
    end else begin
      enc_state_q <= enc_state_d;
      enc_sym_q   <= enc_sym_d;
      enc_valid_q <= enc_valid_d;
    end
  end

  assign encoder_o       = enc_sym_q;
  assign valid_encoder_o = enc_valid_q;

  logic [3:0][5:0]   pm_q, pm_d, acs_pm;
  logic [3:0][D-1:0] surv_q, surv_d, acs_surv;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dec_bit_q, dec_bit_d;
  logic              dec_valid_q, dec_valid_d;
  logic [1:0]        lo_idx, hi_idx, best_idx;
  logic [5:0]        lo_pm, hi_pm;
  logic              norm;

  // State {b,a} is reached from {a,0} and {a,1} with input b.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_acs
      localparam int A = gi % 2;
      localparam int B = gi / 2;
      localparam logic [1:0] EXP0 = 2'(2 * (B ^ A) + B);
      localparam logic [1:0] EXP1 = 2'(2 * (B ^ A ^ 1) + (B ^ 1));
      logic [1:0] diff0, diff1;
      logic [5:0] cand0, cand1;
      logic       take1;

      assign diff0 = decoder_i ^ EXP0;
      assign diff1 = decoder_i ^ EXP1;
      assign cand0 = pm_q[2*A]   + {5'd0, diff0[1]} + {5'd0, diff0[0]};
      assign cand1 = pm_q[2*A+1] + {5'd0, diff1[1]} + {5'd0, diff1[0]};
      // Strict compare: a tie keeps the x=0 predecessor.
      assign take1 = (cand1 < cand0);
      assign acs_pm[gi]   = take1 ? cand1 : cand0;
      assign acs_surv[gi] = {take1 ? surv_q[2*A+1][D-2:0] : surv_q[2*A][D-2:0], B[0]};
    end
  endgenerate

  // Best state is taken from the registered metrics, keeping it off the ACS path.
  always_comb begin
    lo_idx   = (pm_q[1] < pm_q[0]) ? 2'd1 : 2'd0;
    lo_pm    = pm_q[lo_idx];
    hi_idx   = (pm_q[3] < pm_q[2]) ? 2'd3 : 2'd2;
    hi_pm    = pm_q[hi_idx];
    best_idx = (hi_pm < lo_pm) ? hi_idx : lo_idx;
  end

  assign norm = acs_pm[0][5] & acs_pm[1][5] & acs_pm[2][5] & acs_pm[3][5];

  always_comb begin
    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = 1'b0;
    if (enable_decoder_i) begin
      pm_d = acs_pm;
      if (norm) begin
        for (int i = 0; i < 4; i++) begin
          pm_d[i][5] = 1'b0;
        end
      end
      surv_d      = acs_surv;
      dec_bit_d   = surv_q[best_idx][D-1];
      dec_valid_d = (cnt_q == CW'(D));
      if (cnt_q != CW'(D)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q        <= PM_INIT;
      surv_q      <= '0;
      cnt_q       <= '0;
      dec_bit_q   <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_d;
      dec_bit_q   <= dec_bit_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign decoder_o       = dec_bit_q;
  assign decoder_valid_o = dec_valid_q;

endmodule

// File: tb/tb_viterbi_codec.sv
// Scoreboard bench for viterbi_codec: encoder loops back to the decoder through
// one channel register stage that can inject symbol errors.
module tb_viterbi_codec;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_encoder_i = 1'b0;
  logic       encoder_i = 1'b0;
  logic       valid_encoder_o;
  logic [1:0] encoder_o;
  logic       ch_en;
  logic [1:0] ch_sym;
  logic       decoder_o;
  logic       decoder_valid_o;

  viterbi_codec #(.TB_DEPTH(D)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_encoder_i (enable_encoder_i),
    .encoder_i        (encoder_i),
    .valid_encoder_o  (valid_encoder_o),
    .encoder_o        (encoder_o),
    .enable_decoder_i (ch_en),
    .decoder_i        (ch_sym),
    .decoder_o        (decoder_o),
    .decoder_valid_o  (decoder_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic val;
    bit   chk;
    bit   lat;
    int   cyc;
  } exp_t;

  exp_t       dec_q[$];
  logic [1:0] enc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mode = 0;
  int         sent = 0;
  int         ch_idx;
  int         dec_en_cnt;
  int         first_lat = -1;
  bit         seen_valid = 1'b0;
  bit         enc_chk = 1'b0;
  exp_t       mon_x;
  logic [1:0] mon_e;

  logic       dir_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] dir_sym  [8] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};

  // Modes: 0 clean, 1 one bit of symbol 40, 2 both bits of 40, 3 burst 40..42, 4 one error per 16.
  function automatic logic [1:0] err_mask(input int m, input int k);
    case (m)
      1: return (k == 40) ? 2'b01 : 2'b00;
      2: return (k == 40) ? 2'b11 : 2'b00;
      3: return (k >= 40 && k <= 42) ? 2'b11 : 2'b00;
      4: return (k % 16 != 7) ? 2'b00 : (((k / 16) % 2 == 1) ? 2'b10 : 2'b01);
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_en  <= 1'b0;
      ch_sym <= 2'b00;
      ch_idx <= 0;
    end else begin
      ch_en <= valid_encoder_o;
      if (valid_encoder_o) begin
        ch_sym <= encoder_o ^ err_mask(mode, ch_idx);
        ch_idx <= ch_idx + 1;
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) dec_en_cnt <= 0;
    else if (ch_en) dec_en_cnt <= dec_en_cnt + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      seen_valid = 1'b0;
    end else begin
      if (valid_encoder_o && enc_chk) begin
        if (enc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL enc_extra actual=unexpected symbol %0d required=none", encoder_o);
        end else begin
          mon_e = enc_q.pop_front();
          check("enc_sym", int'(encoder_o), int'(mon_e));
        end
      end
      if (decoder_valid_o) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          first_lat  = dec_en_cnt;
        end
        if (dec_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dec_extra actual=unexpected bit %0d required=none", decoder_o);
        end else begin
          mon_x = dec_q.pop_front();
          if (mon_x.chk) check("dec_bit", int'(decoder_o), int'(mon_x.val));
          // Driven half a cycle before the encoder edge, hence D+2 plus one.
          if (mon_x.lat) check("dec_lat", cyc - mon_x.cyc, D + 3);
        end
      end
    end
  end

  task automatic send(input bit en, input bit d, input bit lat);
    exp_t e;
    @(negedge clk);
    enable_encoder_i = en;
    encoder_i        = d;
    if (en) begin
      e.val = d;
      e.chk = !(mode == 3 && sent >= 32 && sent <= 55);
      e.lat = lat;
      e.cyc = cyc;
      dec_q.push_back(e);
      sent++;
    end
  endtask

  task automatic do_reset(input int m);
    @(posedge clk);
    #2;
    rst              = 1'b0;
    enable_encoder_i = 1'b0;
    encoder_i        = 1'b0;
    mode             = m;
    sent             = 0;
    first_lat        = -1;
    dec_q.delete();
    enc_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic finish_run(input string name);
    repeat (6) send(1'b0, 1'b0, 1'b0);
    check({name, "_pending"}, dec_q.size(), D);
    check({name, "_first_lat"}, first_lat, D + 1);
  endtask

  task automatic run(input int m, input int n, input bit gaps, input string name);
    do_reset(m);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) send(1'b0, 1'b0, 1'b0);
      end
      send(1'b1, 1'($urandom_range(0, 1)), !gaps);
    end
    finish_run(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_enc_o", int'(encoder_o), 0);
    check("rst_enc_v", int'(valid_encoder_o), 0);
    check("rst_dec_o", int'(decoder_o), 0);
    check("rst_dec_v", int'(decoder_valid_o), 0);

    // Hand-computed encoder vectors, then continuous error-free loopback.
    do_reset(0);
    enc_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enc_q.push_back(dir_sym[i]);
      send(1'b1, dir_bits[i], 1'b0);
      if (i == 3) begin
        send(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("enc_hold_v", int'(valid_encoder_o), 0);
        check("enc_hold_sym", int'(encoder_o), 1);
      end
    end
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    check("enc_pending", enc_q.size(), 0);
    enc_chk = 1'b0;
    for (int k = 0; k < 256; k++) send(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    finish_run("clean");

    run(1, 120, 1'b0, "single");
    run(2, 120, 1'b0, "double");
    run(3, 120, 1'b0, "burst");
    run(4, 10000, 1'b1, "gaps");

    // Reset mid-stream at symbol 100.
    do_reset(0);
    for (int k = 0; k < 100; k++) send(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    @(posedge clk);
    #2;
    check("pre_rst_dec_v", int'(decoder_valid_o), 1);
    rst              = 1'b0;
    enable_encoder_i = 1'b0;
    #1;
    check("mid_rst_enc_o", int'(encoder_o), 0);
    check("mid_rst_enc_v", int'(valid_encoder_o), 0);
    check("mid_rst_dec_o", int'(decoder_o), 0);
    check("mid_rst_dec_v", int'(decoder_valid_o), 0);
    dec_q.delete();
    sent      = 0;
    first_lat = -1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int k = 0; k < 60; k++) send(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    finish_run("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
